// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D cache line-port arbiter.
// Line geometry defaults are also used by the cache instances.
package mem_arbiter_pkg;

  localparam int unsigned AddrWDefault = 28;
  localparam int unsigned LineWDefault = 128;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnI    = 2'd1,
    OwnD    = 2'd2
  } owner_e;

  // The requester that is not `o`; NONE maps to I so round-robin starts from D after reset.
  function automatic owner_e other_owner(owner_e o);
    return (o == OwnD) ? OwnI : OwnD;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way selector: fixed priority (D over I) or round-robin against
// the previous owner, chosen by RR_EN.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic       i_pend,
  input  logic       d_pend,
  input  logic [1:0] last_owner,
  output logic [1:0] grant
);

  owner_e last;
  owner_e pick;

  assign last = owner_e'(last_owner);

  always_comb begin
    pick = OwnNone;
    if (i_pend && d_pend) begin
      pick = (RR_EN != 0) ? other_owner(last) : OwnD;
    end else if (d_pend) begin
      pick = OwnD;
    end else if (i_pend) begin
      pick = OwnI;
    end
  end

  assign grant = pick;

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I_cache and D_cache line transactions onto one memory port.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned LINE_W = LineWDefault,
  parameter int unsigned RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_cnt,
  output logic [31:0]       perf_d_cnt,
  output logic [31:0]       perf_wait_cnt
`endif
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            grant;
  logic [1:0]        grant_raw;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_pend, d_pend;
  logic              xfer_done;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

  arb_pick #(
    .RR_EN(RR_EN)
  ) u_pick (
    .i_pend    (i_pend),
    .d_pend    (d_pend),
    .last_owner(last_owner_q),
    .grant     (grant_raw)
  );

  assign grant = owner_e'(grant_raw);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      StIdle: begin
        if (grant == OwnD) begin
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Write wins when both strobes are up; the read returns as a fresh request later.
          mem_write_d = d_write;
          mem_read_d  = d_read & ~d_write;
          owner_d     = OwnD;
          state_d     = StBusy;
        end else if (grant == OwnI) begin
          mem_addr_d  = i_addr;
          mem_wdata_d = i_wdata;
          mem_write_d = i_write;
          mem_read_d  = i_read & ~i_write;
          owner_d     = OwnI;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (mem_ready) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_owner_d = owner_q;
          state_d      = StRelease;
        end
      end
      StRelease: begin
        // Dead cycle lets the owner drop its request before re-arbitration.
        owner_d = OwnNone;
        state_d = StIdle;
      end
      default: begin
        owner_d     = OwnNone;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnNone;
      last_owner_q <= OwnI;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Completion is only forwarded while a transaction is live and not being reset away.
  assign xfer_done = rst_n & (state_q == StBusy) & mem_ready;
  assign i_ready   = xfer_done & (owner_q == OwnI);
  assign d_ready   = xfer_done & (owner_q == OwnD);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_d_q, perf_wait_q;
  logic        wait_hit;

  assign wait_hit = ((owner_q == OwnI) & d_pend) | ((owner_q == OwnD) & i_pend);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_i_q    <= '0;
      perf_d_q    <= '0;
      perf_wait_q <= '0;
    end else begin
      if (state_q == StIdle && grant == OwnI) perf_i_q <= perf_i_q + 32'd1;
      if (state_q == StIdle && grant == OwnD) perf_d_q <= perf_d_q + 32'd1;
      if (wait_hit) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_i_cnt    = perf_i_q;
  assign perf_d_cnt    = perf_d_q;
  assign perf_wait_cnt = perf_wait_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow main-memory line port between the I_cache and the D_cache miss/write-back interfaces.
- Sits between the two cache instances and a single shared memory model (128-bit line, address [31:4]).
- Serializes line transactions, one owner at a time.
- Registers the granted request onto the memory port and routes the memory's ready/rdata back to the owner.

Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4])
- LINE_W, 128, line data width
- RR_EN, 1, 1 = round-robin between I and D; 0 = fixed priority, D over I

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_read  in  1  I_cache line read request
- i_write  in  1  I_cache line write request
- i_addr  in  ADDR_W  I_cache line address
- i_wdata  in  LINE_W  I_cache write line
- i_rdata  out  LINE_W  read line returned to I_cache
- i_ready  out  1  I_cache transaction done
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as the i_* ports, for D_cache
- mem_read  out  1  memory read strobe, held until mem_ready
- mem_write  out  1  memory write strobe, held until mem_ready
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line
- mem_ready  in  1  one-cycle memory completion pulse

Behaviour:
- Interface: single clock clk. Synchronous active-low reset rst_n; all state is updated only on the posedge clk.
- Reset values:
  - state=IDLE, owner=NONE, last_owner=I.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - i_ready=0, d_ready=0.
- A requester is pending when its read|write is high.
- States and transitions:
  - IDLE: arbitrate among pending requesters.
  - IDLE, no request: stay in IDLE.
  - IDLE, one pending: grant it.
  - IDLE, both pending, RR_EN=0: grant D.
  - IDLE, both pending, RR_EN=1: grant the requester not equal to last_owner.
  - On grant, at the clock edge:
    - latch the owner's addr and wdata into mem_addr and mem_wdata;
    - latch the op: write wins if the owner has read and write both high;
    - set mem_read or mem_write, set owner, and go to BUSY.
  - BUSY: the memory strobes and addr/wdata are held stable. Requester inputs are ignored, including changes on the owner's inputs.
  - BUSY, mem_ready=1:
    - owner's ready = 1 combinationally in the same cycle;
    - i_rdata and d_rdata both = mem_rdata at all times (only the ready qualifies);
    - at the edge: clear mem_read/mem_write, last_owner=owner, go to RELEASE.
  - RELEASE: one dead cycle with no grant, so the owner can drop its request. Then go to IDLE.
  - A non-owner ready is never asserted.
- Latency:
  - Request present in IDLE at cycle t → mem strobe high from cycle t+1.
  - mem_ready at cycle r → owner ready at cycle r; a new grant is possible at the edge ending cycle r+2.
- Read+write from the same owner: only the write is performed. If the read is still high after RELEASE, it is arbitrated as a new request.
- mem_ready while in IDLE or RELEASE is ignored; no ready is forwarded.
- Reset during BUSY:
  - the next edge forces the reset values;
  - the memory transaction is abandoned and no ready is forwarded;
  - the caches are reset by the same rst_n.
- Starvation bound: with RR_EN=1, a pending requester waits at most one other transaction. With RR_EN=0, I may starve under continuous D traffic (accepted).

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, the block adds three outputs, perf_i_cnt[31:0], perf_d_cnt[31:0] and perf_wait_cnt[31:0]:
  - perf_i_cnt and perf_d_cnt increment on each grant edge to I or D;
  - perf_wait_cnt increments every cycle in which a non-owner requester is pending;
  - all three reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2;
  - owner encoding: NONE, I, D;
  - LINE_W and ADDR_W defaults, shared with the cache.
- One natural sub-module, arb_pick: the combinational 2-way selector (fixed or round-robin) driven by the pending bits and last_owner. The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- I read only, addr 28'h0000010, memory ready after 5 cycles with rdata=128'hA5…A5 → mem_read high from cycle 1, i_ready=1 for one cycle with i_rdata=A5…A5, d_ready stays 0.
- I and D read together, RR_EN=1, last_owner=I → D is served first, then I after RELEASE, with mem_addr switching exactly at the grant edge.
- RR_EN=0 with D requesting back-to-back four times while I is pending → four D grants and no I grant; I is granted once D drops.
- D asserts write and read together, addr 28'h0000123, wdata=128'h1 → mem_write with mem_wdata=1 first, then a separate mem_read transaction to the same address.
- rst_n=0 mid-BUSY, then mem_ready pulses after reset → all outputs return to 0, no i_ready or d_ready, state IDLE.
- MEM_ARB_PERF_EN defined, 3 I grants and 2 D grants with 4 overlap cycles → perf_i_cnt=3, perf_d_cnt=2, perf_wait_cnt=4.
